// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter
// Shares the single core memory port between the CPU (master 0) and the IOPs
// (masters 1..NUM_MASTERS-1). It produces a registered one-hot grant and steers
// the owner's address, write data and byte enables onto memory. Ownership lasts
// for the whole request, is bounded by MAX_HOLD unless locked, and is always
// followed by one dead turnaround cycle.
module memory_bus_arbiter #(
   parameter int NUM_MASTERS  = 2,
   parameter int MAX_HOLD     = 16,
   parameter bit CPU_PRIORITY = 1'b1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_MASTERS-1:0]    req,
   input  logic [NUM_MASTERS-1:0]    lock,
   input  logic [NUM_MASTERS*17-1:0] m_addr,
   input  logic [NUM_MASTERS*32-1:0] m_wdata,
   input  logic [NUM_MASTERS*4-1:0]  m_wr_en,
   output logic [NUM_MASTERS-1:0]    grant,
   output logic [2:0]                owner,
   output logic                      busy,
   output logic [15:31]              mem_address,
   output logic [0:31]               mem_data_out,
   output logic [0:3]                mem_wr_en
);

   localparam int HOLD_W = $clog2(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANTED = 2'd1,
      ST_TURN    = 2'd2
   } state_t;

   state_t                   state_reg;
   logic [NUM_MASTERS-1:0]   grant_reg;
   logic [2:0]               owner_reg;
   logic                     busy_reg;
   logic [2:0]               rr_ptr_reg;
   logic [HOLD_W-1:0]        hold_cnt_reg;

   // Per-master views of the flattened input buses.
   logic [16:0]              addr_slice  [NUM_MASTERS];
   logic [31:0]              wdata_slice [NUM_MASTERS];
   logic [3:0]               wren_slice  [NUM_MASTERS];
   logic [NUM_MASTERS-1:0]   wr_active;

   // Owner-side signals, selected by the registered owner index.
   logic                     owner_req;
   logic                     owner_lock;
   logic                     owner_wr;
   logic                     others_req;
   logic [16:0]              sel_addr;
   logic [31:0]              sel_wdata;
   logic [3:0]               sel_wren;

   // Arbitration result for the IDLE/TURN states.
   logic                     arb_found;
   logic [2:0]               arb_winner;
   logic [NUM_MASTERS-1:0]   arb_onehot;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
         assign addr_slice[gi]  = m_addr[gi*17 +: 17];
         assign wdata_slice[gi] = m_wdata[gi*32 +: 32];
         assign wren_slice[gi]  = m_wr_en[gi*4 +: 4];
         assign wr_active[gi]   = |m_wr_en[gi*4 +: 4];
      end
   endgenerate

   // Pick out the owner's request, lock, enables and bus values; note any competing request.
   always_comb begin
      owner_req  = 1'b0;
      owner_lock = 1'b0;
      owner_wr   = 1'b0;
      others_req = 1'b0;
      sel_addr   = '0;
      sel_wdata  = '0;
      sel_wren   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (owner_reg == 3'(i)) begin
            owner_req  = req[i];
            owner_lock = lock[i];
            owner_wr   = wr_active[i];
            sel_addr   = addr_slice[i];
            sel_wdata  = wdata_slice[i];
            sel_wren   = wren_slice[i];
         end else begin
            others_req = others_req | req[i];
         end
      end
   end

   // Winner: CPU first when prioritised, otherwise the first requester after the last winner.
   always_comb begin
      arb_found  = 1'b0;
      arb_winner = '0;
      if (CPU_PRIORITY && req[0]) begin
         arb_found  = 1'b1;
         arb_winner = '0;
      end else begin
         for (int off = 1; off <= NUM_MASTERS; off++) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
               if (!arb_found && req[i] &&
                   (i == (int'(rr_ptr_reg) + off) % NUM_MASTERS)) begin
                  arb_found  = 1'b1;
                  arb_winner = 3'(i);
               end
            end
         end
      end
      arb_onehot = NUM_MASTERS'(1) << arb_winner;
   end

   // Ownership FSM: grant, release, hold-time preemption and the turnaround cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         grant_reg    <= '0;
         owner_reg    <= '0;
         busy_reg     <= 1'b0;
         rr_ptr_reg   <= '0;
         hold_cnt_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_TURN: begin
               if (arb_found) begin
                  grant_reg    <= arb_onehot;
                  owner_reg    <= arb_winner;
                  busy_reg     <= 1'b1;
                  rr_ptr_reg   <= arb_winner;
                  hold_cnt_reg <= '0;
                  state_reg    <= ST_GRANTED;
               end else begin
                  grant_reg    <= '0;
                  busy_reg     <= 1'b0;
                  state_reg    <= ST_IDLE;
               end
            end
            ST_GRANTED: begin
               // A preemption waits until the owner is not writing this cycle.
               if (!owner_req ||
                   ((hold_cnt_reg == HOLD_LAST) && !owner_lock && others_req && !owner_wr)) begin
                  grant_reg <= '0;
                  busy_reg  <= 1'b0;
                  state_reg <= ST_TURN;
               end else if (hold_cnt_reg != HOLD_LAST) begin
                  hold_cnt_reg <= hold_cnt_reg + 1'b1;
               end
            end
            default: begin
               grant_reg <= '0;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign grant        = grant_reg;
   assign owner        = owner_reg;
   assign busy         = busy_reg;
   assign mem_address  = busy_reg ? sel_addr  : '0;
   assign mem_data_out = busy_reg ? sel_wdata : '0;
   assign mem_wr_en    = busy_reg ? sel_wren  : '0;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter
// Two arbiters side by side: A (2 masters, CPU priority, hold 16) and
// B (3 masters, round-robin, hold 4). Each cycle the stimulus process steps a
// behavioural model and queues the expected outputs; the monitor pops and
// compares one entry per instance shortly after every rising edge.
module tb_memory_bus_arbiter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   // Instance A
   logic        a_reset;
   logic [1:0]  a_req, a_lock;
   logic [33:0] a_addr;
   logic [63:0] a_wdata;
   logic [7:0]  a_we;
   logic [1:0]  a_grant;
   logic [2:0]  a_owner;
   logic        a_busy;
   logic [15:31] a_mem_address;
   logic [0:31]  a_mem_data;
   logic [0:3]   a_mem_we;

   // Instance B
   logic        b_reset;
   logic [2:0]  b_req, b_lock;
   logic [50:0] b_addr;
   logic [95:0] b_wdata;
   logic [11:0] b_we;
   logic [2:0]  b_grant;
   logic [2:0]  b_owner;
   logic        b_busy;
   logic [15:31] b_mem_address;
   logic [0:31]  b_mem_data;
   logic [0:3]   b_mem_we;

   memory_bus_arbiter #(.NUM_MASTERS(2), .MAX_HOLD(16), .CPU_PRIORITY(1'b1)) dut_a (
      .clock(clock), .reset(a_reset), .req(a_req), .lock(a_lock),
      .m_addr(a_addr), .m_wdata(a_wdata), .m_wr_en(a_we),
      .grant(a_grant), .owner(a_owner), .busy(a_busy),
      .mem_address(a_mem_address), .mem_data_out(a_mem_data), .mem_wr_en(a_mem_we)
   );

   memory_bus_arbiter #(.NUM_MASTERS(3), .MAX_HOLD(4), .CPU_PRIORITY(1'b0)) dut_b (
      .clock(clock), .reset(b_reset), .req(b_req), .lock(b_lock),
      .m_addr(b_addr), .m_wdata(b_wdata), .m_wr_en(b_we),
      .grant(b_grant), .owner(b_owner), .busy(b_busy),
      .mem_address(b_mem_address), .mem_data_out(b_mem_data), .mem_wr_en(b_mem_we)
   );

   typedef struct packed {
      logic [7:0]  grant;
      logic        busy;
      logic [2:0]  owner;
      logic [16:0] addr;
      logic [31:0] data;
      logic [3:0]  we;
   } exp_t;

   // Model state: own = -1 when nobody owns the bus (idle or turnaround look alike).
   typedef struct packed {
      int own;
      int hold;
      int rr;
   } ms_t;

   exp_t qa[$];
   exp_t qb[$];
   ms_t  ms_a, ms_b;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;

   // Round-robin with all three requesting: rr starts at 0, so the scan begins at master 1.
   logic [2:0] rr_exp [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
   int         rr_idx      = 0;
   bit         rr_phase    = 1'b1;
   logic [2:0] b_prev_grant = '0;

   function automatic ms_t step(ms_t s, int n, int maxh, bit cpupri, bit rst,
                                logic [7:0] rq, logic [7:0] lk, logic [7:0] wnz);
      ms_t r;
      bit  others;
      int  w;
      r = s;
      others = 1'b0;
      w = -1;
      if (rst) begin
         r.own = -1; r.hold = 0; r.rr = 0;
         return r;
      end
      if (s.own >= 0) begin
         for (int i = 0; i < n; i++) if (i != s.own && rq[i]) others = 1'b1;
         if (!rq[s.own]) r.own = -1;
         else if (s.hold >= maxh - 1 && !lk[s.own] && others && !wnz[s.own]) r.own = -1;
         else if (s.hold < maxh - 1) r.hold = s.hold + 1;
      end else begin
         if (cpupri && rq[0]) w = 0;
         else for (int k = 1; k <= n; k++) if (w < 0 && rq[(s.rr + k) % n]) w = (s.rr + k) % n;
         if (w >= 0) begin r.own = w; r.rr = w; r.hold = 0; end
      end
      return r;
   endfunction

   function automatic exp_t mk_exp(ms_t s, logic [135:0] addr, logic [255:0] data, logic [31:0] we);
      exp_t e;
      e = '0;
      if (s.own >= 0) begin
         e.grant = 8'(1) << s.own;
         e.busy  = 1'b1;
         e.owner = 3'(s.own);
         e.addr  = addr[s.own*17 +: 17];
         e.data  = data[s.own*32 +: 32];
         e.we    = we[s.own*4 +: 4];
      end
      return e;
   endfunction

   // Inputs are already set for the coming edge: predict, queue, advance to the next negedge.
   task automatic tick();
      logic [7:0] wnz_a, wnz_b;
      wnz_a = '0;
      wnz_b = '0;
      for (int i = 0; i < 2; i++) wnz_a[i] = |a_we[i*4 +: 4];
      for (int i = 0; i < 3; i++) wnz_b[i] = |b_we[i*4 +: 4];
      ms_a = step(ms_a, 2, 16, 1'b1, a_reset, 8'(a_req), 8'(a_lock), wnz_a);
      ms_b = step(ms_b, 3, 4, 1'b0, b_reset, 8'(b_req), 8'(b_lock), wnz_b);
      qa.push_back(mk_exp(ms_a, 136'(a_addr), 256'(a_wdata), 32'(a_we)));
      qb.push_back(mk_exp(ms_b, 136'(b_addr), 256'(b_wdata), 32'(b_we)));
      @(negedge clock);
   endtask

   // Monitor: one comparison per instance per cycle, plus the round-robin order check.
   initial begin : monitor
      exp_t ea, aa, eb, ab;
      forever begin
         @(posedge clock);
         #1;
         cyc++;
         if (qa.size() > 0) begin
            ea = qa.pop_front();
            aa.grant = 8'(a_grant);
            aa.busy  = a_busy;
            aa.owner = a_busy ? a_owner : 3'd0;
            aa.addr  = a_mem_address;
            aa.data  = a_mem_data;
            aa.we    = a_mem_we;
            vectors++;
            if (aa !== ea) begin
               miscompares++;
               $display("FAIL inst_a cycle %0d: got grant=%h busy=%b owner=%0d addr=%h data=%h we=%h, want grant=%h busy=%b owner=%0d addr=%h data=%h we=%h",
                        cyc, aa.grant, aa.busy, aa.owner, aa.addr, aa.data, aa.we,
                        ea.grant, ea.busy, ea.owner, ea.addr, ea.data, ea.we);
            end
         end
         if (qb.size() > 0) begin
            eb = qb.pop_front();
            ab.grant = 8'(b_grant);
            ab.busy  = b_busy;
            ab.owner = b_busy ? b_owner : 3'd0;
            ab.addr  = b_mem_address;
            ab.data  = b_mem_data;
            ab.we    = b_mem_we;
            vectors++;
            if (ab !== eb) begin
               miscompares++;
               $display("FAIL inst_b cycle %0d: got grant=%h busy=%b owner=%0d addr=%h data=%h we=%h, want grant=%h busy=%b owner=%0d addr=%h data=%h we=%h",
                        cyc, ab.grant, ab.busy, ab.owner, ab.addr, ab.data, ab.we,
                        eb.grant, eb.busy, eb.owner, eb.addr, eb.data, eb.we);
            end
         end
         if (rr_phase && b_prev_grant == 3'b000 && b_grant != 3'b000 && rr_idx < 4) begin
            vectors++;
            if (b_grant !== rr_exp[rr_idx]) begin
               miscompares++;
               $display("FAIL rr_order #%0d: got grant=%b, want %b", rr_idx, b_grant, rr_exp[rr_idx]);
            end
            rr_idx++;
         end
         b_prev_grant = b_grant;
      end
   end

   // Stimulus: directed scenarios on A while B round-robins, then randomized traffic on both.
   initial begin : stimulus
      ms_a.own = -1; ms_a.hold = 0; ms_a.rr = 0;
      ms_b.own = -1; ms_b.hold = 0; ms_b.rr = 0;
      a_reset = 1'b1; a_req = 2'b11; a_lock = '0; a_addr = '0; a_wdata = '0; a_we = '0;
      b_reset = 1'b1; b_req = 3'b111; b_lock = '0; b_we = '0;
      b_addr  = {17'h1aaaa, 17'h0bbbb, 17'h0cccc};
      b_wdata = {32'hb2b2b2b2, 32'hb1b1b1b1, 32'hb0b0b0b0};

      // Reset held with requests pending
      repeat (2) tick();
      a_reset = 1'b0;
      b_reset = 1'b0;

      // Single IOP write
      a_req = 2'b00;
      tick();
      a_req = 2'b10;
      a_addr[33:17]  = 17'h2a;
      a_wdata[63:32] = 32'h32100021;
      a_we[7:4]      = 4'hf;
      a_addr[16:0]   = 17'h155;
      a_wdata[31:0]  = 32'hdeadbeef;
      a_we[3:0]      = 4'h3;
      repeat (3) tick();
      a_req = 2'b00;
      repeat (2) tick();

      // CPU priority, then CPU drops and IOP takes over after one turnaround
      a_we = '0;
      a_req = 2'b11;
      repeat (3) tick();
      a_req = 2'b10;
      repeat (3) tick();
      a_req = 2'b00;
      repeat (2) tick();

      // Lock blocks preemption; write enables defer it
      a_req  = 2'b10;
      a_lock = 2'b10;
      tick();
      a_req = 2'b11;
      repeat (20) tick();
      a_lock    = 2'b00;
      a_we[7:4] = 4'hf;
      repeat (2) tick();
      a_we[7:4] = 4'h0;
      repeat (4) tick();
      a_req = 2'b00;
      repeat (2) tick();

      // Reset in the middle of an IOP grant, then re-grant
      a_req = 2'b10;
      repeat (3) tick();
      a_reset = 1'b1;
      tick();
      a_reset = 1'b0;
      repeat (3) tick();

      // Randomized traffic
      rr_phase = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         a_reset = ($urandom_range(0, 299) == 0);
         b_reset = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 23) == 0) a_req[i]  = ~a_req[i];
            if ($urandom_range(0, 31) == 0) a_lock[i] = ~a_lock[i];
         end
         for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 9) == 0)  b_req[i]  = ~b_req[i];
            if ($urandom_range(0, 31) == 0) b_lock[i] = ~b_lock[i];
         end
         a_we    = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
         b_we    = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'h000;
         a_addr  = 34'({$urandom, $urandom});
         a_wdata = {$urandom, $urandom};
         b_addr  = 51'({$urandom, $urandom});
         b_wdata = {$urandom, $urandom, $urandom};
         tick();
      end

      @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
